// File: rtl/rgb_gray_pkg.sv
`default_nettype none
// =============================================================================
// Module  : rgb_gray_pkg
// Brief   : Shared constants and types for the RGB565-to-gray CI block.
// Revision: 1.0 - initial release
// =============================================================================
package rgb_gray_pkg;

    typedef logic [1:0] mode_t;

    typedef struct packed {
        logic [7:0] w_b;
        logic [7:0] w_g;
        logic [7:0] w_r;
    } weights_t;

    localparam mode_t c_mode_bt601 = 2'b00;
    localparam mode_t c_mode_bt709 = 2'b01;
    localparam mode_t c_mode_avg   = 2'b10;
    localparam mode_t c_mode_user  = 2'b11;

    localparam weights_t c_weights_bt601 = '{w_b: 8'd29, w_g: 8'd150, w_r: 8'd77};
    localparam weights_t c_weights_bt709 = '{w_b: 8'd19, w_g: 8'd183, w_r: 8'd54};
    localparam weights_t c_weights_avg   = '{w_b: 8'd85, w_g: 8'd86,  w_r: 8'd85};
    localparam weights_t c_weights_reset = c_weights_bt601;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Weights sum to this scale; the weighted sum is renormalised by it.
    localparam int c_weight_scale = 256;
    localparam int c_weight_shift = 8;

    function automatic weights_t select_weights(input mode_t mode, input weights_t user_w);
        weights_t w;
        case (mode)
            c_mode_bt601: w = c_weights_bt601;
            c_mode_bt709: w = c_weights_bt709;
            c_mode_avg:   w = c_weights_avg;
            default:      w = user_w;
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb565_gray_pixel.sv
`default_nettype none
// =============================================================================
// Module  : rgb565_gray_pixel
// Brief   : Combinational RGB565 expand, weighted sum, round and saturate.
// Revision: 1.0 - initial release
// =============================================================================
module rgb565_gray_pixel
    import rgb_gray_pkg::*;
(
    input  logic [15:0] pixel,
    input  weights_t    weights,
    output logic [7:0]  gray
);

    logic [7:0]  w_r8;
    logic [7:0]  w_g8;
    logic [7:0]  w_b8;
    logic [17:0] w_sum;
    logic [9:0]  w_scaled;

    // Replicate the MSBs so full-scale 5/6-bit channels map to 255.
    assign w_r8 = {pixel[15:11], pixel[15:13]};
    assign w_g8 = {pixel[10:5],  pixel[10:9]};
    assign w_b8 = {pixel[4:0],   pixel[4:2]};

    // Worst case 3*255*255+128 fits comfortably in 18 bits.
    assign w_sum = 18'(w_r8 * weights.w_r)
                 + 18'(w_g8 * weights.w_g)
                 + 18'(w_b8 * weights.w_b)
                 + 18'(c_weight_scale / 2);

    assign w_scaled = w_sum[17:c_weight_shift];
    assign gray     = (w_scaled > 10'd255) ? 8'hFF : w_scaled[7:0];

endmodule
`default_nettype wire

// File: rtl/rgb565_gray_ci_multi.sv
`default_nettype none
// =============================================================================
// Module  : rgb565_gray_ci_multi
// Brief   : Multi-cycle CI converting 1-2 RGB565 pixels to 8-bit gray.
// Revision: 1.0 - initial release
// =============================================================================
module rgb565_gray_ci_multi
    import rgb_gray_pkg::*;
#(
    parameter logic [7:0] customInstructionId = 8'h00,
    parameter int         NUM_PIXELS          = 2
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    localparam logic c_last_idx = (NUM_PIXELS == 2) ? 1'b1 : 1'b0;

    logic [1:0]  r_state;
    logic        r_idx;
    logic [31:0] r_pixels;
    mode_t       r_mode;
    weights_t    r_user_w;
    logic [15:0] r_bytes;

    logic        w_accept;
    logic [15:0] w_pixel;
    weights_t    w_weights;
    logic [7:0]  w_gray;
    logic        w_unused_cmd;

    assign w_accept     = start && (ciN == customInstructionId) && (r_state == c_st_idle);
    assign w_pixel      = r_idx ? r_pixels[31:16] : r_pixels[15:0];
    assign w_weights    = select_weights(r_mode, r_user_w);
    assign w_unused_cmd = &{1'b0, valueB[30:2]};

    rgb565_gray_pixel u_pixel (
        .pixel   (w_pixel),
        .weights (w_weights),
        .gray    (w_gray)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= c_st_idle;
            r_idx    <= 1'b0;
            r_pixels <= 32'd0;
            r_mode   <= c_mode_bt601;
            r_user_w <= c_weights_reset;
            r_bytes  <= 16'd0;
            done     <= 1'b0;
            result   <= 32'd0;
        end else begin
            // Output is registered from DONE so result is zero outside the pulse.
            done   <= (r_state == c_st_done);
            result <= (r_state == c_st_done) ? {16'd0, r_bytes} : 32'd0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_idx   <= 1'b0;
                        r_bytes <= 16'd0;
                        if (valueB[31]) begin
                            r_user_w <= '{w_b: valueA[23:16], w_g: valueA[15:8], w_r: valueA[7:0]};
                            r_state  <= c_st_done;
                        end else begin
                            r_pixels <= valueA;
                            r_mode   <= valueB[1:0];
                            r_state  <= c_st_calc;
                        end
                    end
                end
                c_st_calc: begin
                    if (r_idx) begin
                        r_bytes[15:8] <= w_gray;
                    end else begin
                        r_bytes[7:0] <= w_gray;
                    end
                    if (r_idx == c_last_idx) begin
                        r_state <= c_st_done;
                    end else begin
                        r_idx <= 1'b1;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/rgb565_gray_ci_multi.md
RGB565_GRAY_CI_MULTI -- requirements
Module: rgb565_gray_ci_multi

Interface
REQ-001 Parameter customInstructionId, default 8'h00, CI opcode this block answers to.
REQ-002 Parameter NUM_PIXELS, default 2, RGB565 pixels per instruction; legal values 1 and 2 only.
REQ-003 clock  in  1  rising-edge system clock.
REQ-004 reset  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  CPU CI start strobe, single cycle.
REQ-006 ciN  in  8  CI opcode; the block acts only when ciN == customInstructionId.
REQ-007 valueA  in  32  pixel k in valueA[16k+15:16k] (R[15:11] G[10:5] B[4:0]); the weight word on a weight-load command.
REQ-008 valueB  in  32  command: [31]=weight-load, [1:0]=mode.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 result  out  32  gray bytes; SHALL be 32'd0 whenever done is 0.

Function
REQ-011 Accept start only when start=1, ciN matches and state=IDLE; otherwise ignore start with no state change.
REQ-012 States: IDLE -> CALC on accepted conversion start; CALC -> DONE after NUM_PIXELS cycles; DONE -> IDLE after exactly 1 cycle.
REQ-013 Operands SHALL be latched at the accept edge; later valueA/valueB changes have no effect.
REQ-014 CALC processes one pixel per cycle, pixel 0 first, via one shared pixel datapath.
REQ-015 Latency: for start accepted at edge T, done=1 for exactly the cycle following edge T+NUM_PIXELS+1.
REQ-016 Channel expansion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
REQ-017 Gray = (R8*wR + G8*wG + B8*wB + 128) >> 8, computed at 18 bits minimum, saturated to 255.
REQ-018 Mode 00 BT.601 weights (77,150,29); 01 BT.709 (54,183,19); 10 average (85,86,85); 11 user register.
REQ-019 Weight-load (valueB[31]=1, accepted): user register <= {wB=valueA[23:16], wG=valueA[15:8], wR=valueA[7:0]}; state IDLE -> DONE, so done pulses one cycle after the accept edge with result 0.
REQ-020 Result packing: pixel k gray in result[8k+7:8k]; all unused bytes 0.
REQ-021 Start asserted during CALC/DONE SHALL be dropped, not queued; done never pulses for it.

Reset
REQ-022 reset low: state=IDLE, done=0, result=0, latched operands=0, user weights=(77,150,29), immediately and independent of clock.
REQ-023 reset low mid-CALC aborts the instruction; no done pulse after release.
REQ-024 First accepted start at or after the first rising edge following reset release is processed normally.

Structure
REQ-025 Package rgb_gray_pkg SHALL hold mode encodings, the three fixed weight triplets, the BT.601 reset weights, the state encoding and the 256 weight scale.
REQ-026 One sub-module rgb565_gray_pixel: combinational expand, weighted sum, round and saturate for one pixel and one weight triplet.
REQ-027 The parent holds the FSM, pixel counter, operand/weight registers and result byte-lane assembly; one registered byte per CALC cycle.

Verification
REQ-028 NUM_PIXELS=2, mode 00, valueA=32'h0000FFFF -> single done pulse at T+3, result=32'h000000FF.
REQ-029 Mode 00, pixel0=16'hF800 -> byte0=8'h4D; mode 01, pixel0=16'h07E0 -> byte0=8'hB6.
REQ-030 Weight-load valueA=32'h00FFFFFF, then mode 11, pixel0=16'hFFFF -> byte0=8'hFF (saturated); pixel0=16'h0000 -> 8'h00.
REQ-031 ciN mismatch with start=1 -> done stays 0 and result stays 0 for 10 cycles; start repeated during CALC -> exactly one done pulse.
REQ-032 reset asserted at T+1 of a conversion -> done=0 and result=0 throughout; after release, mode 11 uses weights (77,150,29) (16'hF800 -> 8'h4D).
REQ-033 Sweep each channel 0..max singly in modes 00-10 against a reference model; all bytes match.
